// File: rtl/au_exec_ctrl.sv
`timescale 1ns/1ps
// au_exec_ctrl
//   Single-issue execute controller around a combinational 16-bit add/sub
//   arithmetic unit (AU). Accepts one command at a time over valid/ready,
//   reads operands from an internal 8x16 register file, drives the AU, then
//   captures the AU result/flags and writes the result back.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while IDLE
//   cmd_op              00 ADD, 01 SUB, 10 LDI, 11 CMP
//   cmd_rd/rs1/rs2      destination and source register addresses
//   cmd_imm             immediate for LDI
//   au_op_sel, au_a/b   to AU: 0 add / 1 subtract, operands (registered)
//   au_res, au_v/c/n/z  from AU: result and flags
//   flags               status register {v,c,n,z}
//   done                one-cycle pulse while a command is in writeback
//   dbg_addr/dbg_data   combinational register file read port
module au_exec_ctrl #(
   parameter int NREG = 8,
   parameter int W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [2:0]   cmd_rd,
   input  logic [2:0]   cmd_rs1,
   input  logic [2:0]   cmd_rs2,
   input  logic [W-1:0] cmd_imm,
   output logic         au_op_sel,
   output logic [W-1:0] au_a,
   output logic [W-1:0] au_b,
   input  logic [W-1:0] au_res,
   input  logic         au_v,
   input  logic         au_c,
   input  logic         au_n,
   input  logic         au_z,
   output logic [3:0]   flags,
   output logic         done,
   input  logic [2:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                             OP_LDI = 2'b10, OP_CMP = 2'b11} op_t;

   state_t         state_q;
   op_t            op_q;
   op_t            cmd_op_e;
   logic [2:0]     rd_q;
   logic [W-1:0]   imm_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           sel_q;
   logic [W-1:0]   res_q;
   logic [3:0]     flags_q;
   logic           done_q;
   logic [W-1:0]   regs_q [NREG];

   assign cmd_op_e  = op_t'(cmd_op);
   assign cmd_ready = (state_q == IDLE);
   assign au_op_sel = sel_q;
   assign au_a      = a_q;
   assign au_b      = b_q;
   assign flags     = flags_q;
   assign done      = done_q;
   assign dbg_data  = regs_q[dbg_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         rd_q    <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q  <= cmd_op_e;
                  rd_q  <= cmd_rd;
                  imm_q <= cmd_imm;
                  if (cmd_op_e == OP_LDI) begin
                     // LDI skips the AU; done rises together with WB entry
                     done_q  <= 1'b1;
                     state_q <= WB;
                  end else begin
                     // Operands are loaded here so the AU sees them for all of EXEC
                     a_q     <= regs_q[cmd_rs1];
                     b_q     <= regs_q[cmd_rs2];
                     sel_q   <= (cmd_op_e == OP_SUB) || (cmd_op_e == OP_CMP);
                     state_q <= EXEC;
                  end
               end
            end
            EXEC: begin
               res_q   <= au_res;
               flags_q <= {au_v, au_c, au_n, au_z};
               sel_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= WB;
            end
            WB: begin
               done_q <= 1'b0;
               case (op_q)
                  OP_ADD, OP_SUB: regs_q[rd_q] <= res_q;
                  OP_LDI:         regs_q[rd_q] <= imm_q;
                  default:        ;
               endcase
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_au_exec_ctrl.sv
`timescale 1ns/1ps
module tb_au_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
   logic [15:0] cmd_imm;
   logic        au_op_sel;
   logic [15:0] au_a, au_b, au_res;
   logic        au_v, au_c, au_n, au_z;
   logic [3:0]  flags;
   logic        done;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   // AU stub: manual values for directed steps, a small add/sub model otherwise
   logic        auto_au;
   logic [15:0] man_res;
   logic [3:0]  man_flags;
   logic [15:0] mdl_res;
   assign mdl_res = au_op_sel ? (au_a - au_b) : (au_a + au_b);
   assign au_res  = auto_au ? mdl_res : man_res;
   assign {au_v, au_c, au_n, au_z} = auto_au ? {2'b00, mdl_res[15], (mdl_res == 16'h0)}
                                             : man_flags;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   au_exec_ctrl #(.NREG(8), .W(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .au_op_sel(au_op_sel), .au_a(au_a), .au_b(au_b), .au_res(au_res),
      .au_v(au_v), .au_c(au_c), .au_n(au_n), .au_z(au_z),
      .flags(flags), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdreg(input logic [2:0] a, output logic [15:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   // Presents a command before the next edge; returns 1ns after the accepting edge
   task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] imm);
      @(negedge clk);
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic [1:0]  b_op  [4];
      logic [2:0]  b_rd  [4];
      logic [2:0]  b_rs1 [4];
      logic [2:0]  b_rs2 [4];
      logic [15:0] b_imm [4];
      int idx, dones, cyc;
      logic acc;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
      cmd_rs2 = '0; cmd_imm = '0; dbg_addr = '0; auto_au = 1'b0;
      man_res = '0; man_flags = '0;
      #12;
      // ---- reset state ----
      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_flags", flags, 0);
      chk("rst_au_a", au_a, 0);
      chk("rst_au_b", au_b, 0);
      chk("rst_sel", au_op_sel, 0);
      for (int i = 0; i < 8; i++) begin
         rdreg(3'(i), d);
         chk("rst_reg", d, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // ---- LDI R1 = 5 ----
      issue(2'b10, 3'd1, 3'd0, 3'd0, 16'h0005);
      chk("ldi_done", done, 1);
      chk("ldi_ready_low", cmd_ready, 0);
      chk("ldi_flags", flags, 0);
      rdreg(3'd1, d);
      chk("ldi_r1_old_in_wb", d, 16'h0000);
      tick();
      chk("ldi_done_clr", done, 0);
      chk("ldi_ready", cmd_ready, 1);
      rdreg(3'd1, d);
      chk("ldi_r1", d, 16'h0005);

      // ---- LDI R2 = 3 ----
      issue(2'b10, 3'd2, 3'd0, 3'd0, 16'h0003);
      tick();
      rdreg(3'd2, d);
      chk("ldi_r2", d, 16'h0003);

      // ---- SUB R3 = R1 - R2 ----
      issue(2'b01, 3'd3, 3'd1, 3'd2, 16'hBEEF);
      chk("sub_au_a", au_a, 16'h0005);
      chk("sub_au_b", au_b, 16'h0003);
      chk("sub_sel", au_op_sel, 1);
      chk("sub_exec_done", done, 0);
      chk("sub_exec_ready", cmd_ready, 0);
      man_res = 16'h0002; man_flags = 4'b0100;
      tick();
      man_res = 16'hFFFF; man_flags = 4'b1111;
      chk("sub_wb_done", done, 1);
      chk("sub_flags", flags, 4'b0100);
      chk("sub_wb_sel", au_op_sel, 0);
      rdreg(3'd3, d);
      chk("sub_r3_old_in_wb", d, 16'h0000);
      tick();
      chk("sub_done_clr", done, 0);
      rdreg(3'd3, d);
      chk("sub_r3", d, 16'h0002);

      // ---- CMP R1, R1 (rd = R5, must stay untouched) ----
      issue(2'b11, 3'd5, 3'd1, 3'd1, 16'h0000);
      chk("cmp_au_a", au_a, 16'h0005);
      chk("cmp_au_b", au_b, 16'h0005);
      chk("cmp_sel", au_op_sel, 1);
      man_res = 16'h0000; man_flags = 4'b0101;
      tick();
      man_res = 16'h7777; man_flags = 4'b0000;
      chk("cmp_done", done, 1);
      chk("cmp_flags", flags, 4'b0101);
      tick();
      rdreg(3'd5, d);
      chk("cmp_r5_unchanged", d, 16'h0000);
      rdreg(3'd1, d);
      chk("cmp_r1_unchanged", d, 16'h0005);

      // ---- LDI keeps flags ----
      issue(2'b10, 3'd4, 3'd0, 3'd0, 16'h8001);
      tick();
      chk("ldi_keeps_flags", flags, 4'b0101);
      rdreg(3'd4, d);
      chk("ldi_r4", d, 16'h8001);

      // ---- ADD R1 = R1 + R1 ----
      issue(2'b00, 3'd1, 3'd1, 3'd1, 16'h0000);
      chk("add_au_a", au_a, 16'h0005);
      chk("add_au_b", au_b, 16'h0005);
      chk("add_sel", au_op_sel, 0);
      man_res = 16'h000A; man_flags = 4'b0000;
      tick();
      man_res = 16'h0000; man_flags = 4'b1111;
      chk("add_done", done, 1);
      chk("add_flags", flags, 4'b0000);
      tick();
      rdreg(3'd1, d);
      chk("add_r1", d, 16'h000A);

      // ---- cmd_valid held high for 4 commands ----
      b_op[0] = 2'b10; b_rd[0] = 3'd6; b_rs1[0] = 3'd0; b_rs2[0] = 3'd0; b_imm[0] = 16'h1234;
      b_op[1] = 2'b10; b_rd[1] = 3'd7; b_rs1[1] = 3'd0; b_rs2[1] = 3'd0; b_imm[1] = 16'h00FF;
      b_op[2] = 2'b00; b_rd[2] = 3'd0; b_rs1[2] = 3'd6; b_rs2[2] = 3'd7; b_imm[2] = 16'h0000;
      b_op[3] = 2'b01; b_rd[3] = 3'd2; b_rs1[3] = 3'd0; b_rs2[3] = 3'd7; b_imm[3] = 16'h0000;
      auto_au = 1'b1;
      idx = 0; dones = 0; cyc = 0;
      while (dones < 4 && cyc < 40) begin
         @(negedge clk);
         if (idx < 4) begin
            if (cmd_ready) begin
               cmd_op = b_op[idx]; cmd_rd = b_rd[idx]; cmd_rs1 = b_rs1[idx];
               cmd_rs2 = b_rs2[idx]; cmd_imm = b_imm[idx];
            end
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         acc = cmd_valid && cmd_ready;
         @(posedge clk);
         cyc++;
         if (acc) idx++;
         #1;
         if (acc) chk("b2b_ready_low_after_accept", cmd_ready, 0);
         if (done) begin
            dones++;
            chk("b2b_ready_low_on_done", cmd_ready, 0);
         end
      end
      cmd_valid = 1'b0;
      chk("b2b_done_count", dones, 4);
      chk("b2b_accept_count", idx, 4);
      chk("b2b_cycles", cyc, 9);
      tick();
      rdreg(3'd6, d);
      chk("b2b_r6", d, 16'h1234);
      rdreg(3'd7, d);
      chk("b2b_r7", d, 16'h00FF);
      rdreg(3'd0, d);
      chk("b2b_r0", d, 16'h1333);
      rdreg(3'd2, d);
      chk("b2b_r2_order", d, 16'h1234);
      auto_au = 1'b0;

      // ---- reset in the middle of EXEC ----
      issue(2'b00, 3'd3, 3'd1, 3'd2, 16'h0000);
      man_res = 16'h5555; man_flags = 4'b1010;
      chk("mid_in_exec", cmd_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_flags", flags, 0);
      chk("mid_rst_au_a", au_a, 0);
      rdreg(3'd1, d);
      chk("mid_rst_r1", d, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_no_done", done, 0);
      end
      rdreg(3'd3, d);
      chk("mid_r3_no_wb", d, 0);
      chk("mid_flags_after", flags, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
